// File: rtl/oai21_bist_seq.sv
// oai21_bist_seq: self-test sequencer for one OAI21 cell (Y = ~((A|B)&C)).
// Sweeps {A,B,C} through all 8 patterns per pass (even passes ascend, odd passes descend),
// waits SETTLE_CYC cycles per vector, compares the registered Y against the golden function.
// Ports:
//   CLK, R (async active-low reset), start (1-cycle run request), abort (sync, kills a run)
//   dut_y  : cell output (asynchronous path, registered internally before compare)
//   dut_a/b/c : registered drives to the cell inputs
//   busy, done, pass, err_count[3:0] (saturating), fail_vld, fail_vec[2:0] = {A,B,C} of first miss
module oai21_bist_seq #(
  parameter int SETTLE_CYC = 4,
  parameter int NUM_PASSES = 2
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_vld,
  output logic [2:0] fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] LP_PASS_LAST   = 4'(NUM_PASSES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_vec;
  logic [3:0] r_pass_idx;
  logic [7:0] r_settle_cnt;
  logic       r_y_q;
  logic [2:0] r_dut_abc;
  logic [3:0] r_err_count;
  logic       r_fail_vld;
  logic [2:0] r_fail_vec;
  logic       r_done;
  logic       r_pass;

  logic w_exp;
  logic w_mismatch;
  logic w_desc;
  logic w_last_vec;
  logic w_last_pass;
  logic w_run_start;

  // vec = {A,B,C}
  assign w_exp       = ~((r_vec[2] | r_vec[1]) & r_vec[0]);
  assign w_mismatch  = (r_y_q != w_exp);
  assign w_desc      = r_pass_idx[0];
  assign w_last_vec  = w_desc ? (r_vec == 3'd0) : (r_vec == 3'd7);
  assign w_last_pass = (r_pass_idx == LP_PASS_LAST);
  // A new run may only be launched from the resting states; abort has no say there.
  assign w_run_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_APPLY;
      S_APPLY:  w_next = abort ? S_IDLE : S_SETTLE;
      S_SETTLE: begin
        if (abort)                              w_next = S_IDLE;
        else if (r_settle_cnt == LP_SETTLE_LAST) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)                          w_next = S_IDLE;
        else if (w_last_vec && w_last_pass) w_next = S_DONE;
        else                                w_next = S_APPLY;
      end
      S_DONE:   if (start) w_next = S_APPLY;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_vec        <= 3'd0;
      r_pass_idx   <= 4'd0;
      r_settle_cnt <= 8'd0;
      r_y_q        <= 1'b0;
      r_dut_abc    <= 3'd0;
      r_err_count  <= 4'd0;
      r_fail_vld   <= 1'b0;
      r_fail_vec   <= 3'd0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_y_q <= dut_y;
      unique case (r_state)
        S_IDLE: r_dut_abc <= 3'd0;
        S_APPLY: begin
          if (abort) begin
            r_dut_abc <= 3'd0;
          end else begin
            r_dut_abc    <= r_vec;
            r_settle_cnt <= 8'd0;
          end
        end
        S_SETTLE: begin
          if (abort) r_dut_abc    <= 3'd0;
          else       r_settle_cnt <= r_settle_cnt + 8'd1;
        end
        S_SAMPLE: begin
          if (abort) begin
            r_dut_abc <= 3'd0;
          end else begin
            if (w_mismatch) begin
              if (r_err_count != 4'd15) r_err_count <= r_err_count + 4'd1;
              if (!r_fail_vld) begin
                r_fail_vld <= 1'b1;
                r_fail_vec <= r_vec;
              end
            end
            // At a pass boundary vec stays put so the next pass restarts from the same end.
            if (w_last_vec) begin
              if (!w_last_pass) r_pass_idx <= r_pass_idx + 4'd1;
            end else begin
              r_vec <= w_desc ? (r_vec - 3'd1) : (r_vec + 3'd1);
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_pass <= (r_err_count == 4'd0);
        end
        default: ;
      endcase
      if (w_run_start) begin
        r_vec       <= 3'd0;
        r_pass_idx  <= 4'd0;
        r_err_count <= 4'd0;
        r_fail_vld  <= 1'b0;
        r_fail_vec  <= 3'd0;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
      end
    end
  end

  assign dut_a     = r_dut_abc[2];
  assign dut_b     = r_dut_abc[1];
  assign dut_c     = r_dut_abc[0];
  assign busy      = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_vld  = r_fail_vld;
  assign fail_vec  = r_fail_vec;

endmodule
